bloom_filter_ctrl: RTL
======================

# bloom_filter_ctrl

Request sequencer for the counting Bloom filter: accepts probe/insert/delete requests from NREQ independent requesters, arbitrates round-robin, drives the filter's Addr/WE/increment pins with correct settle timing, and returns a per-request response carrying the filter result. Sits between the page-tracking clients and the single BloomFilter instance, which has no handshake of its own and must see at most one operation in flight.

## Interface
- NREQ, 2: number of requesters (≥2).
- ADDR_W, 57: request/filter address width.
- CNT_W, 32: statistics counter width (used only with stats compiled in).
- CLK  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  request valid per requester.
- req_ready  output  NREQ  one-hot accept strobe.
- req_op  input  2*NREQ  op per requester: 00 PROBE, 01 INSERT, 10 DELETE, 11 reserved.
- req_addr  input  ADDR_W*NREQ  address per requester.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  $clog2(NREQ)  index of requester being answered.
- rsp_hit  output  1  filter result after the op (probe: present; write: post-op result).
- rsp_err  output  1  reserved op rejected.
- bf_addr  output  ADDR_W  to filter Addr.
- bf_we  output  1  to filter WE.
- bf_inc  output  1  to filter increment.
- bf_result  input  1  from filter result.
- busy  output  1  high in any state other than IDLE.
- stat_probe, stat_insert, stat_delete, stat_hit  output  CNT_W each  (only with BLOOM_CTRL_STATS_EN).

## Operation
- States: IDLE, WR, SETTLE, RD, RESP.
- IDLE: if any req_valid, grant = first valid index at or after rr_ptr (wrapping); req_ready[grant]=1 combinationally this cycle only; capture op, addr, id; rr_ptr <= grant+1 mod NREQ. Next: INSERT/DELETE -> WR, PROBE -> RD, reserved -> RESP with err=1.
- WR: bf_we=1, bf_inc=1 for INSERT / 0 for DELETE, exactly one cycle. Next SETTLE.
- SETTLE: bf_we=0; bf_result sampled into hit at end of cycle. Next RESP.
- RD: bf_we=0; bf_result sampled into hit at end of cycle. Next RESP.
- RESP: rsp_valid=1, rsp_id/rsp_hit/rsp_err stable until rsp_valid && rsp_ready; then IDLE. No new grant in the handshake cycle.
- bf_addr holds captured address from grant until next grant; bf_we/bf_inc never high outside WR.
- Reserved op: no filter access, rsp_hit=0, rsp_err=1.
- rsp_err=0 for all legal ops.

## Timing
- Reset values: state IDLE, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_hit 0, rsp_err 0, bf_addr 0, bf_we 0, bf_inc 0, busy 0, all stats 0.
- Grant at cycle T: probe rsp_valid at T+2; write rsp_valid at T+3; reserved at T+1 (rsp_ready held high).
- Max throughput: one probe per 3 cycles, one write per 4 cycles.
- rst asserted mid-operation: next edge forces all reset values; a WR cycle coinciding with rst still drives bf_we (filter update is not rolled back); no response issued for the aborted request.
- Single requester valid continuously: served back-to-back; rr_ptr still advances.

## Configuration
- BLOOM_CTRL_STATS_EN defined: four CNT_W counters, incremented at RESP handshake: stat_probe/insert/delete by op, stat_hit on probe with hit=1; saturate at all-ones; reserved ops not counted.
- Not defined: stat ports and counters absent; no other behaviour change.

## Structure
- Package bloom_ctrl_pkg: op enum (PROBE/INSERT/DELETE/RSVD), state enum, ADDR_W default constant.
- Sub-module bloom_rr_arb: NREQ-wide round-robin grant with pointer input, one-hot and index outputs.

## Test plan
- Reset, then probe addr 0x0000_3000 from req 0 with filter result 0 -> req_ready[0] at T, rsp_valid at T+2, rsp_hit=0, rsp_id=0.
- Insert 0x5000 from req 1 -> bf_we=1, bf_inc=1 only at T+1; bf_result driven 1 in SETTLE -> rsp_hit=1 at T+3.
- Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; no two bf_we pulses closer than 4 cycles.
- rsp_ready held 0 for 5 cycles -> rsp fields stable, no req_ready asserted, busy=1.
- Op 11 from req 1 -> rsp_err=1 at T+1, bf_we never asserted; rst asserted during a WR -> outputs at reset values next cycle, no response.
- With BLOOM_CTRL_STATS_EN, CNT_W=4: 17 inserts -> stat_insert=15 (saturated).

Source files
------------

// File: rtl/bloom_ctrl_pkg.sv
// bloom_ctrl_pkg
//   Shared types and constants for the Bloom filter request sequencer:
//   operation encoding carried on req_op, controller state encoding, the
//   default filter address width, and a small op classification helper.
//   Imported by bloom_rr_arb and bloom_filter_ctrl.
package bloom_ctrl_pkg;

  localparam int ADDR_W_DEFAULT = 57;

  // Operation codes as they appear on each requester's 2-bit req_op slice.
  typedef enum logic [1:0] {
    OP_PROBE  = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RD     = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Insert and delete both modify the filter's counters.
  function automatic logic op_is_write(input op_e op);
    return (op == OP_INSERT) || (op == OP_DELETE);
  endfunction

endpackage

// File: rtl/bloom_rr_arb.sv
// bloom_rr_arb
//   Purely combinational round-robin arbiter. Searches the request vector
//   starting at index ptr and wrapping, and grants the first valid request.
//   Ports:
//     valid      in   NREQ           request vector
//     ptr        in   $clog2(NREQ)   index with highest priority (< NREQ)
//     grant      out  NREQ           one-hot grant (all zero when none valid)
//     grant_idx  out  $clog2(NREQ)   binary index of the granted requester
//     grant_any  out  1              at least one request valid
module bloom_rr_arb
  import bloom_ctrl_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    grant_any
);

  localparam int IW = $clog2(NREQ);

  // cand_idx[k] is the requester examined at search offset k from ptr.
  logic [IW-1:0]   cand_idx [NREQ];
  logic [NREQ-1:0] cand_valid;

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [IW:0] sum;
    // One extra bit so ptr+offset cannot overflow before the wrap test.
    assign sum           = {1'b0, ptr} + (IW+1)'(gi);
    assign cand_idx[gi]  = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ))
                                                  : sum[IW-1:0];
    assign cand_valid[gi] = valid[cand_idx[gi]];
  end

  // Scan from the farthest offset down so the nearest valid one wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx[i];
      end
    end
  end

  for (gi = 0; gi < NREQ; gi++) begin : g_grant
    assign grant[gi] = grant_any && (grant_idx == IW'(gi));
  end

endmodule

// File: rtl/bloom_filter_ctrl.sv
// bloom_filter_ctrl
//   Sequences probe/insert/delete requests from NREQ requesters onto a single
//   counting Bloom filter that has no handshake. One operation in flight:
//   IDLE grants (round-robin), WR pulses the write strobe for one cycle,
//   SETTLE/RD sample the filter result, RESP holds the response until taken.
//   Optional build macro: BLOOM_CTRL_STATS_EN adds four saturating counters.
//   Ports:
//     CLK, rst                clock, synchronous active-high reset
//     req_valid/req_ready     per-requester request handshake (ready one-hot)
//     req_op                  2 bits per requester: probe/insert/delete/rsvd
//     req_addr                ADDR_W bits per requester
//     rsp_valid/rsp_ready     response handshake
//     rsp_id/rsp_hit/rsp_err  answered requester, filter result, reserved-op flag
//     bf_addr/bf_we/bf_inc    filter address, write enable, increment select
//     bf_result               filter result input
//     busy                    controller not in IDLE
//     stat_probe/insert/delete/hit  counters (BLOOM_CTRL_STATS_EN only)
module bloom_filter_ctrl
  import bloom_ctrl_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int CNT_W  = 32
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [ADDR_W*NREQ-1:0]   req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_hit,
  output logic                     rsp_err,
  output logic [ADDR_W-1:0]        bf_addr,
  output logic                     bf_we,
  output logic                     bf_inc,
  input  logic                     bf_result,
  output logic                     busy
`ifdef BLOOM_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]         stat_probe,
  output logic [CNT_W-1:0]         stat_insert,
  output logic [CNT_W-1:0]         stat_delete,
  output logic [CNT_W-1:0]         stat_hit
`endif
);

  localparam int IW = $clog2(NREQ);

  state_e            state_reg, state_next;
  logic [IW-1:0]     rr_ptr_reg;
  op_e               op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [IW-1:0]     id_reg;
  logic              hit_reg;
  logic              err_reg;

  // Per-requester views of the flattened op/address buses.
  logic [1:0]        op_arr   [NREQ];
  logic [ADDR_W-1:0] addr_arr [NREQ];

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_arr[gi]   = req_op[2*gi +: 2];
    assign addr_arr[gi] = req_addr[ADDR_W*gi +: ADDR_W];
  end

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  bloom_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .valid     (req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  op_e           sel_op;
  logic          grant_take;
  logic [IW-1:0] ptr_after_grant;

  assign sel_op          = op_e'(op_arr[arb_idx]);
  assign grant_take      = (state_reg == ST_IDLE) && arb_any;
  assign ptr_after_grant = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      rr_ptr_reg <= '0;
      op_reg     <= OP_PROBE;
      addr_reg   <= '0;
      id_reg     <= '0;
      hit_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_take) begin
        op_reg     <= sel_op;
        addr_reg   <= addr_arr[arb_idx];
        id_reg     <= arb_idx;
        rr_ptr_reg <= ptr_after_grant;
        err_reg    <= (sel_op == OP_RSVD);
        // Reserved ops never sample the filter, so hit must start cleared.
        hit_reg    <= 1'b0;
      end
      if (state_reg == ST_SETTLE || state_reg == ST_RD) begin
        hit_reg <= bf_result;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    bf_we      = 1'b0;
    bf_inc     = 1'b0;
    busy       = (state_reg != ST_IDLE);
    case (state_reg)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready = arb_grant;
          if (op_is_write(sel_op)) begin
            state_next = ST_WR;
          end else if (sel_op == OP_PROBE) begin
            state_next = ST_RD;
          end else begin
            state_next = ST_RESP;
          end
        end
      end
      ST_WR: begin
        // Decoded from state alone, so a reset in this cycle cannot cancel
        // the write already presented to the filter.
        bf_we      = 1'b1;
        bf_inc     = (op_reg == OP_INSERT);
        state_next = ST_SETTLE;
      end
      ST_SETTLE: state_next = ST_RESP;
      ST_RD:     state_next = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        // Return to IDLE only; the next grant happens one cycle later.
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bf_addr = addr_reg;
  assign rsp_id  = id_reg;
  assign rsp_hit = hit_reg;
  assign rsp_err = err_reg;

`ifdef BLOOM_CTRL_STATS_EN
  logic                  rsp_fire;
  logic [3:0]            cnt_inc;
  logic [3:0][CNT_W-1:0] cnt_val;

  assign rsp_fire   = rsp_valid && rsp_ready;
  assign cnt_inc[0] = rsp_fire && (op_reg == OP_PROBE);
  assign cnt_inc[1] = rsp_fire && (op_reg == OP_INSERT);
  assign cnt_inc[2] = rsp_fire && (op_reg == OP_DELETE);
  assign cnt_inc[3] = rsp_fire && (op_reg == OP_PROBE) && hit_reg;

  for (gi = 0; gi < 4; gi++) begin : g_stat
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge CLK) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
    assign cnt_val[gi] = cnt_reg;
  end

  assign stat_probe  = cnt_val[0];
  assign stat_insert = cnt_val[1];
  assign stat_delete = cnt_val[2];
  assign stat_hit    = cnt_val[3];
`else
  // Without counters CNT_W only has to be a legal width; nothing is built.
  if (CNT_W < 1) begin : g_cnt_w_invalid
  end
`endif

endmodule
